// File: rtl/demux_1to8_32b_collector_pkg.sv
// Shared definitions for the 1-to-8 word collector.
// Holds the slot count, pointer and count widths, the FILL/FULL state encoding,
// the out_data packing helper and a popcount used by the direct-address build.
package demux_1to8_32b_collector_pkg;

    localparam int unsigned SLOTS = 8;
    localparam int unsigned PTR_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Bit offset of a slot inside the packed out_data bus.
    function automatic int unsigned slot_offset(input int unsigned slot, input int unsigned width);
        return slot * width;
    endfunction

    // Number of set bits in an 8-bit slot mask.
    function automatic logic [CNT_W-1:0] popcount8(input logic [SLOTS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/demux_1to8_32b_collector_decoder_3to8.sv
// 3-bit index to one-hot 8-bit write-enable, gated by the accept strobe.
// Ports:
//   idx       in  [2:0]  slot index
//   en        in         accept strobe; all enables low when clear
//   onehot_c  out [7:0]  combinational one-hot write enable
module decoder_3to8
    import demux_1to8_32b_collector_pkg::*;
(
    input  logic [PTR_W-1:0] idx,
    input  logic             en,
    output logic [SLOTS-1:0] onehot_c
);

    // One enable per slot, only when a word is actually accepted.
    always_comb begin
        onehot_c = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            onehot_c[i] = en && (idx == PTR_W'(i));
        end
    end

endmodule

// File: rtl/demux_1to8_32b_collector.sv
// Collects a valid/ready stream of WIDTH-bit words into 8 slot registers and
// presents them as one 8*WIDTH block once every slot holds fresh data.
// Optional macro DIRECT_ADDR_EN: words are written to slot[in_sel] and a
// written-mask decides fullness; otherwise an internal pointer fills 0..7.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data word, in_sel slot (macro only)
//   out_valid/out_ready   downstream block handshake
//   out_data              slot i at [i*WIDTH +: WIDTH]
//   fill_count            slots filled, 0..8
module demux_1to8_32b_collector
    import demux_1to8_32b_collector_pkg::*;
#(
    parameter int unsigned WIDTH = 32
)
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [PTR_W-1:0]       in_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SLOTS*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       fill_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] fill_count_q, fill_count_d;
    logic [WIDTH-1:0] slot_q [SLOTS];
    logic [WIDTH-1:0] slot_d [SLOTS];
    logic             accept_c;
    logic [PTR_W-1:0] wr_idx_c;
    logic [SLOTS-1:0] wr_en_c;

`ifdef DIRECT_ADDR_EN
    logic [SLOTS-1:0] mask_q, mask_d;

    assign wr_idx_c = in_sel;
`else
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             unused_in_sel;

    assign wr_idx_c      = ptr_q;
    assign unused_in_sel = ^in_sel;
`endif

    // Handshake outputs decode straight from the state flop.
    assign in_ready   = (state_q == FILL);
    assign out_valid  = (state_q == FULL);
    assign fill_count = fill_count_q;
    assign accept_c   = in_valid && (state_q == FILL);

    decoder_3to8 u_dec (
        .idx      (wr_idx_c),
        .en       (accept_c),
        .onehot_c (wr_en_c)
    );

    // Pack slots onto the wide output bus.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            out_data[slot_offset(i, WIDTH) +: WIDTH] = slot_q[i];
        end
    end

    // Next-state, slot writes and counters.
    always_comb begin
        state_d      = state_q;
        fill_count_d = fill_count_q;
        for (int i = 0; i < int'(SLOTS); i++) begin
            slot_d[i] = wr_en_c[i] ? in_data : slot_q[i];
        end
`ifdef DIRECT_ADDR_EN
        mask_d = mask_q;
`else
        ptr_d = ptr_q;
`endif
        case (state_q)
            FILL: begin
                if (accept_c) begin
`ifdef DIRECT_ADDR_EN
                    // Rewrites of a written slot leave the count unchanged.
                    mask_d       = mask_q | wr_en_c;
                    fill_count_d = popcount8(mask_d);
                    if (mask_d == '1) begin
                        state_d = FULL;
                    end
`else
                    ptr_d        = ptr_q + PTR_W'(1);
                    fill_count_d = fill_count_q + CNT_W'(1);
                    if (fill_count_q == CNT_W'(SLOTS - 1)) begin
                        state_d = FULL;
                    end
`endif
                end
            end
            FULL: begin
                // Slot data is kept; only the bookkeeping restarts.
                if (out_ready) begin
                    state_d      = FILL;
                    fill_count_d = '0;
`ifdef DIRECT_ADDR_EN
                    mask_d = '0;
`else
                    ptr_d = '0;
`endif
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FILL;
            fill_count_q <= '0;
            for (int i = 0; i < int'(SLOTS); i++) begin
                slot_q[i] <= '0;
            end
`ifdef DIRECT_ADDR_EN
            mask_q <= '0;
`else
            ptr_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fill_count_q <= fill_count_d;
            for (int i = 0; i < int'(SLOTS); i++) begin
                slot_q[i] <= slot_d[i];
            end
`ifdef DIRECT_ADDR_EN
            mask_q <= mask_d;
`else
            ptr_q <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_demux_1to8_32b_collector.sv
module tb_demux_1to8_32b_collector;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic [2:0]   in_sel;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [3:0]   fill_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [255:0] exp_blk;

    demux_1to8_32b_collector #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fill_count (fill_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic ov, input logic ir, input logic [3:0] fc);
        check({tag, "_out_valid"}, 256'(out_valid), 256'(ov));
        check({tag, "_in_ready"}, 256'(in_ready), 256'(ir));
        check({tag, "_fill_count"}, 256'(fill_count), 256'(fc));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_sel    = 3'd0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state and an idle cycle.
        check_status("reset", 1'b0, 1'b1, 4'd0);
        check("reset_out_data", out_data, 256'h0);
        step();
        check_status("idle", 1'b0, 1'b1, 4'd0);

        // out_ready while empty does nothing.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_status("stray_out_ready", 1'b0, 1'b1, 4'd0);

        // Back-to-back stream 0..7.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            in_sel   = 3'(i);
            step();
            check($sformatf("b2b_count%0d", i), 256'(fill_count), 256'(i + 1));
        end
        exp_blk = {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0};
        check_status("b2b_full", 1'b1, 1'b0, 4'd8);
        check("b2b_out_data", out_data, exp_blk);

        // A 9th word held while FULL must not be taken.
        in_data = 32'hDEADBEEF;
        in_sel  = 3'd0;
        step();
        step();
        check_status("held_9th", 1'b1, 1'b0, 4'd8);
        check("held_9th_data", out_data, exp_blk);

        // One-cycle out_ready drains the block; contents are retained.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_status("drain", 1'b0, 1'b1, 4'd0);
        check("drain_retained", out_data, exp_blk);

        in_valid = 1'b1;
        in_data  = 32'hA5A5A5A5;
        in_sel   = 3'd0;
        step();
        in_valid = 1'b0;
        check("post_drain_count", 256'(fill_count), 256'd1);
        check("post_drain_slot0", 256'(out_data[31:0]), 256'h A5A5A5A5);
        check("post_drain_slot1", 256'(out_data[63:32]), 256'h1);

        // Four more accepts (five total), then reset mid-block with in_valid high.
        for (int i = 1; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0DE0000 + 32'(i);
            in_sel   = 3'(i);
            step();
        end
        check("pre_reset_count", 256'(fill_count), 256'd5);
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_status("mid_reset", 1'b0, 1'b1, 4'd0);
        check("mid_reset_out_data", out_data, 256'h0);

        // Gapped stream 11111111..88888888 with bubbles carrying junk data.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h11111111 * 32'(i + 1);
            in_sel   = 3'(i);
            step();
            check($sformatf("gap_count%0d", i), 256'(fill_count), 256'(i + 1));
            in_valid = 1'b0;
            in_data  = 32'hBADBAD00;
            in_sel   = 3'(7 - i);
            step();
            check($sformatf("gap_bubble%0d", i), 256'(fill_count), 256'(i + 1));
        end
        exp_blk = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                   32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        check_status("gap_full", 1'b1, 1'b0, 4'd8);
        check("gap_out_data", out_data, exp_blk);

        // Drain with a word offered in the same cycle: no bypass.
        in_valid  = 1'b1;
        in_data   = 32'hFEEDFACE;
        in_sel    = 3'd0;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_status("no_bypass", 1'b0, 1'b1, 4'd0);
        check("no_bypass_data", out_data, exp_blk);

`ifdef DIRECT_ADDR_EN
        // Direct addressing: slot 7 written twice, then 0..6.
        in_valid = 1'b1;
        in_sel   = 3'd7;
        in_data  = 32'h70;
        step();
        check("da_first7", 256'(fill_count), 256'd1);
        in_data = 32'h77;
        step();
        check("da_rewrite7", 256'(fill_count), 256'd1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("da_not_full%0d", i), 256'(out_valid), 256'd0);
            in_sel  = 3'(i);
            in_data = 32'(i);
            step();
            check($sformatf("da_count%0d", i), 256'(fill_count), 256'(i + 2));
        end
        in_valid = 1'b0;
        exp_blk = {32'h77, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0};
        check_status("da_full", 1'b1, 1'b0, 4'd8);
        check("da_out_data", out_data, exp_blk);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_status("da_drain", 1'b0, 1'b1, 4'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
